// File: rtl/ddr_cmd_sequencer.sv
// DDR3 command sequencer: buffers command words in a small FIFO and plays
// them out on the half-rate PHY command bus, one word per clk_div cycle
// followed by a programmable number of NOP cycles.
//
// Ports:
//   clk_div, rst        half-rate clock, async active-high reset
//   en                  run enable (start on level, graceful stop on drop)
//   cmd_*               command word input with valid/ready handshake
//   in_a/in_ba/in_ras/in_cas/in_we/in_cke/in_odt
//                       {second,first} half outputs toward the PHY
//   in_tri              pad tristate, high while idle
//   busy, done, underrun
//                       status: not idle, end-of-sequence pulse, sticky
//                       empty-FIFO-when-due flag
module ddr_cmd_sequencer #(
    parameter int unsigned ADDRESS_NUMBER = 15,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                        clk_div,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [ADDRESS_NUMBER-1:0]   cmd_a,
    input  logic [2:0]                  cmd_ba,
    input  logic [2:0]                  cmd_rcw,
    input  logic                        cmd_cke,
    input  logic                        cmd_odt,
    input  logic [7:0]                  cmd_skip,
    input  logic                        cmd_last,
    output logic [2*ADDRESS_NUMBER-1:0] in_a,
    output logic [5:0]                  in_ba,
    output logic [1:0]                  in_ras,
    output logic [1:0]                  in_cas,
    output logic [1:0]                  in_we,
    output logic [1:0]                  in_cke,
    output logic [1:0]                  in_odt,
    output logic                        in_tri,
    output logic                        busy,
    output logic                        done,
    output logic                        underrun
);

    localparam int unsigned AW     = ADDRESS_NUMBER;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned SKIP_W = 8;

    typedef struct packed {
        logic [AW-1:0]     a;
        logic [2:0]        ba;
        logic [2:0]        rcw;
        logic              cke;
        logic              odt;
        logic [SKIP_W-1:0] skip;
        logic              last;
    } cmd_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SKIP,
        ST_DRAIN
    } state_t;

    // FIFO storage and bookkeeping
    cmd_word_t         fifo_q [FIFO_DEPTH];
    cmd_word_t         wr_word_c;
    cmd_word_t         head_c;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              push_c, pop_c;

    // Sequencer state
    state_t            state_q, state_d;
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
    logic              last_q, last_d;
    logic              underrun_q, underrun_d;
    logic              busy_q, busy_d;

    // Stage 1: what this cycle's state emits (a/ba/cke/odt hold last issued)
    logic [AW-1:0]     s1_a_q, s1_a_d;
    logic [2:0]        s1_ba_q, s1_ba_d;
    logic [2:0]        s1_rcw_q, s1_rcw_d;
    logic              s1_cke_q, s1_cke_d;
    logic              s1_odt_q, s1_odt_d;
    logic              s1_tri_q, s1_tri_d;
    logic              s1_done_q, s1_done_d;

    // Stage 2: PHY-facing output registers, both halves duplicated
    logic [2*AW-1:0]   in_a_q, in_a_d;
    logic [5:0]        in_ba_q, in_ba_d;
    logic [1:0]        in_ras_q, in_ras_d;
    logic [1:0]        in_cas_q, in_cas_d;
    logic [1:0]        in_we_q, in_we_d;
    logic [1:0]        in_cke_q, in_cke_d;
    logic [1:0]        in_odt_q, in_odt_d;
    logic              in_tri_q, in_tri_d;
    logic              done_q, done_d;

    // Incoming word packing and handshake
    always_comb begin
        wr_word_c      = '0;
        wr_word_c.a    = cmd_a;
        wr_word_c.ba   = cmd_ba;
        wr_word_c.rcw  = cmd_rcw;
        wr_word_c.cke  = cmd_cke;
        wr_word_c.odt  = cmd_odt;
        wr_word_c.skip = cmd_skip;
        wr_word_c.last = cmd_last;
        push_c         = cmd_valid && (count_q < CNT_W'(FIFO_DEPTH));
        pop_c          = (state_q == ST_ISSUE) && (count_q != '0);
        head_c         = fifo_q[rd_ptr_q];
    end

    // Pointer wrap and occupancy; push is refused when full, pop when empty
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        cmd_ready_d = (count_d < CNT_W'(FIFO_DEPTH));
    end

    // FIFO storage write (no reset needed: occupancy guards reads)
    always_ff @(posedge clk_div) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= wr_word_c;
        end
    end

    // Next-state and stage-1 emission
    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        last_d     = last_q;
        underrun_d = underrun_q;
        s1_a_d     = s1_a_q;
        s1_ba_d    = s1_ba_q;
        s1_cke_d   = s1_cke_q;
        s1_odt_d   = s1_odt_q;
        s1_rcw_d   = 3'b111;
        s1_tri_d   = 1'b0;
        s1_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                s1_tri_d = 1'b1;
                if (en) begin
                    state_d    = ST_ISSUE;
                    underrun_d = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (pop_c) begin
                    s1_a_d   = head_c.a;
                    s1_ba_d  = head_c.ba;
                    s1_rcw_d = head_c.rcw;
                    s1_cke_d = head_c.cke;
                    s1_odt_d = head_c.odt;
                    last_d   = head_c.last;
                    if (head_c.skip != '0) begin
                        state_d    = ST_SKIP;
                        skip_cnt_d = head_c.skip - SKIP_W'(1);
                    end else if (head_c.last || !en) begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    underrun_d = 1'b1;
                end
            end
            ST_SKIP: begin
                // Counter was loaded with skip-1, so skip NOP cycles are spent here
                if (skip_cnt_q == '0) begin
                    state_d = (last_q || !en) ? ST_DRAIN : ST_ISSUE;
                end else begin
                    skip_cnt_d = skip_cnt_q - SKIP_W'(1);
                end
            end
            ST_DRAIN: begin
                s1_done_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Stage-2 outputs: same value in both halves of the half-rate bus
    always_comb begin
        in_a_d   = {s1_a_q, s1_a_q};
        in_ba_d  = {s1_ba_q, s1_ba_q};
        in_ras_d = {2{s1_rcw_q[2]}};
        in_cas_d = {2{s1_rcw_q[1]}};
        in_we_d  = {2{s1_rcw_q[0]}};
        in_cke_d = {2{s1_cke_q}};
        in_odt_d = {2{s1_odt_q}};
        in_tri_d = s1_tri_q;
        done_d   = s1_done_q;
    end

    // State and output registers
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
            skip_cnt_q  <= '0;
            last_q      <= 1'b0;
            underrun_q  <= 1'b0;
            busy_q      <= 1'b0;
            s1_a_q      <= '0;
            s1_ba_q     <= '0;
            s1_rcw_q    <= 3'b111;
            s1_cke_q    <= 1'b1;
            s1_odt_q    <= 1'b0;
            s1_tri_q    <= 1'b1;
            s1_done_q   <= 1'b0;
            in_a_q      <= '0;
            in_ba_q     <= '0;
            in_ras_q    <= 2'b11;
            in_cas_q    <= 2'b11;
            in_we_q     <= 2'b11;
            in_cke_q    <= 2'b11;
            in_odt_q    <= 2'b00;
            in_tri_q    <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_ready_q <= cmd_ready_d;
            state_q     <= state_d;
            skip_cnt_q  <= skip_cnt_d;
            last_q      <= last_d;
            underrun_q  <= underrun_d;
            busy_q      <= busy_d;
            s1_a_q      <= s1_a_d;
            s1_ba_q     <= s1_ba_d;
            s1_rcw_q    <= s1_rcw_d;
            s1_cke_q    <= s1_cke_d;
            s1_odt_q    <= s1_odt_d;
            s1_tri_q    <= s1_tri_d;
            s1_done_q   <= s1_done_d;
            in_a_q      <= in_a_d;
            in_ba_q     <= in_ba_d;
            in_ras_q    <= in_ras_d;
            in_cas_q    <= in_cas_d;
            in_we_q     <= in_we_d;
            in_cke_q    <= in_cke_d;
            in_odt_q    <= in_odt_d;
            in_tri_q    <= in_tri_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign in_a      = in_a_q;
    assign in_ba     = in_ba_q;
    assign in_ras    = in_ras_q;
    assign in_cas    = in_cas_q;
    assign in_we     = in_we_q;
    assign in_cke    = in_cke_q;
    assign in_odt    = in_odt_q;
    assign in_tri    = in_tri_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Self-checking bench for ddr_cmd_sequencer: directed scenarios, a
// table-driven FIFO fill, and randomized command sequences compared against
// an output-trace model built from a queue of accepted command words.
module tb_ddr_cmd_sequencer;

    localparam int unsigned AN    = 15;
    localparam int unsigned DEPTH = 4;

    logic              clk_div = 1'b0;
    logic              rst;
    logic              en;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [AN-1:0]     cmd_a;
    logic [2:0]        cmd_ba;
    logic [2:0]        cmd_rcw;
    logic              cmd_cke;
    logic              cmd_odt;
    logic [7:0]        cmd_skip;
    logic              cmd_last;
    logic [2*AN-1:0]   in_a;
    logic [5:0]        in_ba;
    logic [1:0]        in_ras, in_cas, in_we, in_cke, in_odt;
    logic              in_tri, busy, done, underrun;

    ddr_cmd_sequencer #(.ADDRESS_NUMBER(AN), .FIFO_DEPTH(DEPTH)) dut (
        .clk_div(clk_div), .rst(rst), .en(en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_ba(cmd_ba), .cmd_rcw(cmd_rcw),
        .cmd_cke(cmd_cke), .cmd_odt(cmd_odt), .cmd_skip(cmd_skip), .cmd_last(cmd_last),
        .in_a(in_a), .in_ba(in_ba), .in_ras(in_ras), .in_cas(in_cas), .in_we(in_we),
        .in_cke(in_cke), .in_odt(in_odt), .in_tri(in_tri),
        .busy(busy), .done(done), .underrun(underrun)
    );

    always #5 clk_div = ~clk_div;

    typedef struct packed {
        logic [AN-1:0] a;
        logic [2:0]    ba;
        logic [2:0]    rcw;
        logic          cke;
        logic          odt;
        logic [7:0]    skip;
        logic          last;
    } word_t;

    typedef struct packed {
        logic [2*AN-1:0] a;
        logic [5:0]      ba;
        logic [1:0]      ras, cas, we, cke, odt;
        logic            tri_s;
        logic            done;
    } out_t;

    typedef struct {
        logic [AN-1:0] a;
        logic [7:0]    skip;
        logic          last;
        logic          exp_ready;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Model: words accepted but not yet issued, and the last issued levels
    word_t         model_fifo[$];
    logic [AN-1:0] last_a;
    logic [2:0]    last_ba;
    logic          last_cke, last_odt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk_div);
        #1;
    endtask

    task automatic model_reset;
        model_fifo.delete();
        last_a   = '0;
        last_ba  = '0;
        last_cke = 1'b1;
        last_odt = 1'b0;
    endtask

    function automatic out_t nop_out(input logic tri_v, input logic done_v);
        out_t o;
        o.a     = {last_a, last_a};
        o.ba    = {last_ba, last_ba};
        o.ras   = 2'b11;
        o.cas   = 2'b11;
        o.we    = 2'b11;
        o.cke   = {2{last_cke}};
        o.odt   = {2{last_odt}};
        o.tri_s = tri_v;
        o.done  = done_v;
        return o;
    endfunction

    function automatic out_t cmd_out(input word_t w);
        out_t o;
        o.a     = {w.a, w.a};
        o.ba    = {w.ba, w.ba};
        o.ras   = {2{w.rcw[2]}};
        o.cas   = {2{w.rcw[1]}};
        o.we    = {2{w.rcw[0]}};
        o.cke   = {2{w.cke}};
        o.odt   = {2{w.odt}};
        o.tri_s = 1'b0;
        o.done  = 1'b0;
        return o;
    endfunction

    function automatic out_t actual_out();
        out_t o;
        o.a = in_a; o.ba = in_ba; o.ras = in_ras; o.cas = in_cas; o.we = in_we;
        o.cke = in_cke; o.odt = in_odt; o.tri_s = in_tri; o.done = done;
        return o;
    endfunction

    function automatic word_t mk_word(input logic [AN-1:0] a, input logic [2:0] ba,
                                      input logic [2:0] rcw, input logic cke, input logic odt,
                                      input logic [7:0] skip, input logic last);
        word_t w;
        w.a = a; w.ba = ba; w.rcw = rcw; w.cke = cke; w.odt = odt; w.skip = skip; w.last = last;
        return w;
    endfunction

    task automatic drive_word(input word_t w);
        cmd_a = w.a; cmd_ba = w.ba; cmd_rcw = w.rcw; cmd_cke = w.cke;
        cmd_odt = w.odt; cmd_skip = w.skip; cmd_last = w.last;
    endtask

    task automatic reset_dut;
        rst = 1'b1; en = 1'b0; cmd_valid = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        model_reset();
    endtask

    // Push one word while the sequencer is idle; the model decides acceptance
    task automatic push(input word_t w);
        logic acc;
        acc = (model_fifo.size() < DEPTH);
        drive_word(w);
        cmd_valid = 1'b1;
        check("ready_before_push", cmd_ready, acc);
        tick;
        cmd_valid = 1'b0;
        if (acc) model_fifo.push_back(w);
        check("ready_after_push", cmd_ready, model_fifo.size() < DEPTH);
    endtask

    // Enable and compare the full output trace; en drops once the last word
    // to be issued is visible (that word must be last or have skip>0)
    task automatic run_seq(input int n_issue);
        out_t exp_q[$];
        int   drop_idx;
        exp_q.push_back(nop_out(1'b1, 1'b0));
        exp_q.push_back(nop_out(1'b1, 1'b0));
        drop_idx = 0;
        for (int i = 0; i < n_issue && model_fifo.size() > 0; i++) begin
            word_t w;
            w = model_fifo.pop_front();
            exp_q.push_back(cmd_out(w));
            drop_idx = exp_q.size() - 1;
            last_a = w.a; last_ba = w.ba; last_cke = w.cke; last_odt = w.odt;
            for (int s = 0; s < int'(w.skip); s++) exp_q.push_back(nop_out(1'b0, 1'b0));
            if (w.last) break;
        end
        exp_q.push_back(nop_out(1'b0, 1'b1));
        exp_q.push_back(nop_out(1'b1, 1'b0));
        en = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            tick;
            check($sformatf("trace[%0d]", k), actual_out(), exp_q[k]);
            if (k == 0) check("busy_start", busy, 1'b1);
            if (k == drop_idx) en = 1'b0;
        end
        check("busy_end", busy, 1'b0);
        check("underrun_clear", underrun, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[5];
        word_t w;
        for (int i = 0; i < 5; i++) begin
            tbl[i].a         = AN'(16'h0100 + i);
            tbl[i].skip      = 8'd0;
            tbl[i].last      = (i == 3);
            tbl[i].exp_ready = (i < DEPTH);
        end

        rst = 1'b1; en = 1'b0; cmd_valid = 1'b0;
        drive_word('0);
        model_reset();
        #1;
        check("rst_async_out", actual_out(), nop_out(1'b1, 1'b0));
        reset_dut();
        check("reset_out", actual_out(), nop_out(1'b1, 1'b0));
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_underrun", underrun, 1'b0);
        check("reset_ready", cmd_ready, 1'b1);

        // Single command, skip=2, last
        push(mk_word(AN'(16'h1234), 3'd5, 3'b011, 1'b1, 1'b1, 8'd2, 1'b1));
        run_seq(8);
        check("in_a_held", in_a, {AN'(16'h1234), AN'(16'h1234)});

        // Table-driven fill past depth, then back-to-back skip=0 issue
        for (int i = 0; i < 5; i++) begin
            check($sformatf("tbl_ready[%0d]", i), cmd_ready, tbl[i].exp_ready);
            push(mk_word(tbl[i].a, 3'(i), 3'b101, 1'b1, 1'(i), tbl[i].skip, tbl[i].last));
        end
        check("full_ready", cmd_ready, 1'b0);
        run_seq(8);

        // Underrun on empty FIFO, then a late push issues two edges later
        en = 1'b1;
        repeat (3) tick;
        check("ur_tri", in_tri, 1'b0);
        check("ur_flag", underrun, 1'b1);
        check("ur_nop", actual_out(), nop_out(1'b0, 1'b0));
        w = mk_word(AN'(16'h0ABC), 3'd2, 3'b110, 1'b0, 1'b1, 8'd0, 1'b1);
        drive_word(w);
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        check("late_k", actual_out(), nop_out(1'b0, 1'b0));
        tick;
        check("late_k1", actual_out(), nop_out(1'b0, 1'b0));
        en = 1'b0;
        tick;
        check("late_k2_issue", actual_out(), cmd_out(w));
        last_a = w.a; last_ba = w.ba; last_cke = w.cke; last_odt = w.odt;
        tick;
        check("late_done", actual_out(), nop_out(1'b0, 1'b1));
        tick;
        check("late_idle", actual_out(), nop_out(1'b1, 1'b0));
        check("ur_sticky", underrun, 1'b1);

        // en drop during a long skip: finish it, drain, keep the rest queued
        push(mk_word(AN'(16'h7001), 3'd1, 3'b010, 1'b1, 1'b0, 8'd10, 1'b0));
        push(mk_word(AN'(16'h7002), 3'd3, 3'b001, 1'b1, 1'b1, 8'd1, 1'b0));
        push(mk_word(AN'(16'h7003), 3'd7, 3'b100, 1'b0, 1'b0, 8'd0, 1'b1));
        run_seq(1);
        run_seq(8);

        // Randomized sequences against the trace model
        for (int r = 0; r < 10; r++) begin
            int n;
            n = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) tick;
                push(mk_word(AN'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                             1'($urandom), 8'($urandom_range(0, 5)), (i == n - 1)));
            end
            run_seq(n);
        end

        // Reset in the middle of SKIP
        reset_dut();
        push(mk_word(AN'(16'h5555), 3'd6, 3'b000, 1'b0, 1'b1, 8'd10, 1'b1));
        push(mk_word(AN'(16'h2222), 3'd4, 3'b011, 1'b1, 1'b1, 8'd0, 1'b1));
        en = 1'b1;
        repeat (5) tick;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst_out", actual_out(), nop_out(1'b1, 1'b0));
        check("midrst_ready", cmd_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_underrun", underrun, 1'b0);
        en = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        en = 1'b1;
        repeat (3) tick;
        check("midrst_fifo_empty", underrun, 1'b1);
        check("midrst_nop", actual_out(), nop_out(1'b0, 1'b0));
        reset_dut();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
